// File: rtl/bnc_pkg.sv
// Shared types for the Bulls & Cows round controller.
// Digit 0 of a guess or secret sits in bits [3:0].
package bnc_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int MAX_DIGIT  = 9;

    typedef logic [3:0] digit_t;
    typedef digit_t [NUM_DIGITS-1:0] guess_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GUESS,
        S_SCORE,
        S_FRAME,
        S_REPORT,
        S_FINISHED
    } ctrl_state_t;

endpackage

// File: rtl/guess_checker.sv
// Combinational legality check for a four-digit code.
// A code is legal when every digit is decimal and no digit repeats.
module guess_checker
    import bnc_pkg::*;
(
    input  guess_t code,
    output logic   valid
);

    always_comb begin
        valid = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (code[i] > digit_t'(MAX_DIGIT)) valid = 1'b0;
            for (int j = i + 1; j < NUM_DIGITS; j++) begin
                if (code[i] == code[j]) valid = 1'b0;
            end
        end
    end

endmodule

// File: rtl/game_round_controller.sv
// Round sequencer: accepts a guess, registers the external scorer's
// result, handshakes a panel redraw and reports back to the solver.
module game_round_controller
    import bnc_pkg::*;
#(
    parameter int          MAX_GUESSES    = 10,
    parameter logic [15:0] SECRET_DEFAULT = 16'h8475,
    parameter int          FRAME_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        secret_we,
    input  logic [15:0] secret_in,
    output logic [15:0] secret_out,
    input  logic        guess_valid,
    output logic        guess_ready,
    input  logic [15:0] guess_in,
    output logic [15:0] score_guess,
    input  logic [2:0]  score_bulls,
    input  logic [2:0]  score_cows,
    output logic        write_frame,
    input  logic        frame_written,
    output logic        result_valid,
    output logic [2:0]  result_bulls,
    output logic [2:0]  result_cows,
    output logic        result_invalid,
    output logic [3:0]  attempts,
    output logic        frame_timeout,
    output logic        done,
    output logic        win
);

    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    ctrl_state_t state, state_nx;
    logic [TW-1:0] tmr;
    logic secret_ok, guess_ok;
    logic idle_like, xfer, tmo, at_max, won;

    guess_checker u_secret_chk (
        .code  (guess_t'(secret_in)),
        .valid (secret_ok)
    );

    guess_checker u_guess_chk (
        .code  (guess_t'(guess_in)),
        .valid (guess_ok)
    );

    assign idle_like    = (state == S_IDLE) || (state == S_FINISHED);
    assign xfer         = (state == S_WAIT_GUESS) && guess_valid;
    assign tmo          = (state == S_FRAME) && !frame_written
                       && (tmr == TW'(FRAME_TIMEOUT - 1));
    assign at_max       = (attempts == 4'(MAX_GUESSES));
    assign won          = (result_bulls == 3'd4);

    // Handshake outputs are pure state decodes so reset drops them at once.
    assign guess_ready  = (state == S_WAIT_GUESS);
    assign write_frame  = (state == S_FRAME);
    assign result_valid = (state == S_REPORT);
    assign done         = (state == S_FINISHED);

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_FINISHED: begin
                if (start) state_nx = S_WAIT_GUESS;
            end
            S_WAIT_GUESS: begin
                if (guess_valid) state_nx = guess_ok ? S_SCORE : S_REPORT;
            end
            S_SCORE: state_nx = S_FRAME;
            S_FRAME: begin
                if (frame_written || tmo) state_nx = S_REPORT;
            end
            S_REPORT: begin
                if (result_invalid)  state_nx = S_WAIT_GUESS;
                else if (won)        state_nx = S_FINISHED;
                else if (at_max)     state_nx = S_FINISHED;
                else                 state_nx = S_WAIT_GUESS;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            secret_out     <= SECRET_DEFAULT;
            score_guess    <= '0;
            result_bulls   <= '0;
            result_cows    <= '0;
            result_invalid <= 1'b0;
            attempts       <= '0;
            frame_timeout  <= 1'b0;
            win            <= 1'b0;
            tmr            <= '0;
        end else begin
            state <= state_nx;
            if (idle_like && secret_we && secret_ok) begin
                secret_out <= secret_in;
            end
            if (idle_like && start) begin
                attempts      <= '0;
                win           <= 1'b0;
                frame_timeout <= 1'b0;
            end
            if (xfer) begin
                score_guess    <= guess_in;
                result_invalid <= !guess_ok;
                result_bulls   <= '0;
                result_cows    <= '0;
            end
            if (state == S_SCORE) begin
                result_bulls <= score_bulls;
                result_cows  <= score_cows;
                if (!at_max) attempts <= attempts + 4'd1;
            end
            if (state == S_FRAME) tmr <= tmr + 1'b1;
            else                  tmr <= '0;
            if (tmo) frame_timeout <= 1'b1;
            if ((state == S_REPORT) && !result_invalid && won) begin
                win <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_game_round_controller.sv
// Scenario bench for game_round_controller with a behavioural scorer
// and a scoreboard of expected round results.
module tb_game_round_controller;

    localparam int MAXG = 3;
    localparam int FT   = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        secret_we = 1'b0;
    logic [15:0] secret_in = '0;
    logic [15:0] secret_out;
    logic        guess_valid = 1'b0;
    logic        guess_ready;
    logic [15:0] guess_in = '0;
    logic [15:0] score_guess;
    logic [2:0]  score_bulls, score_cows;
    logic        write_frame;
    logic        frame_written;
    logic        result_valid;
    logic [2:0]  result_bulls, result_cows;
    logic        result_invalid;
    logic [3:0]  attempts;
    logic        frame_timeout;
    logic        done;
    logic        win;

    logic        fw = 1'b1;
    assign frame_written = fw;

    always #5 clk = ~clk;

    game_round_controller #(
        .MAX_GUESSES    (MAXG),
        .SECRET_DEFAULT (16'h8475),
        .FRAME_TIMEOUT  (FT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .secret_we      (secret_we),
        .secret_in      (secret_in),
        .secret_out     (secret_out),
        .guess_valid    (guess_valid),
        .guess_ready    (guess_ready),
        .guess_in       (guess_in),
        .score_guess    (score_guess),
        .score_bulls    (score_bulls),
        .score_cows     (score_cows),
        .write_frame    (write_frame),
        .frame_written  (frame_written),
        .result_valid   (result_valid),
        .result_bulls   (result_bulls),
        .result_cows    (result_cows),
        .result_invalid (result_invalid),
        .attempts       (attempts),
        .frame_timeout  (frame_timeout),
        .done           (done),
        .win            (win)
    );

    function automatic logic [2:0] f_bulls(logic [15:0] s, logic [15:0] g);
        logic [2:0] n = 0;
        for (int i = 0; i < 4; i++)
            if (s[i*4 +: 4] == g[i*4 +: 4]) n++;
        return n;
    endfunction

    function automatic logic [2:0] f_cows(logic [15:0] s, logic [15:0] g);
        logic [2:0] n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && g[i*4 +: 4] == s[j*4 +: 4]) n++;
        return n;
    endfunction

    // External scorer stand-in
    always_comb begin
        score_bulls = f_bulls(secret_out, score_guess);
        score_cows  = f_cows(secret_out, score_guess);
    end

    typedef struct {
        logic [2:0] b;
        logic [2:0] c;
        logic       inv;
        int         lat;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    logic [15:0] exp_secret = 16'h8475;
    int          total = 0;
    int          bad = 0;
    bit          ok, got;
    int          lat, wf;
    logic [2:0]  rb, rc;
    logic        rinv, rto;

    task automatic push(input logic [15:0] g, input bit inv, input int l);
        exp_t x;
        x.inv = inv;
        x.b   = inv ? 3'd0 : f_bulls(exp_secret, g);
        x.c   = inv ? 3'd0 : f_cows(exp_secret, g);
        x.lat = l;
        q.push_back(x);
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        start = 1'b0;
        secret_we = 1'b0;
        guess_valid = 1'b0;
        fw = 1'b1;
        exp_secret = 16'h8475;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_game(input bit we, input logic [15:0] s);
        start = 1'b1;
        secret_we = we;
        secret_in = s;
        @(negedge clk);
        start = 1'b0;
        secret_we = 1'b0;
    endtask

    // Offer a guess and collect the round result within a cycle budget.
    task automatic do_guess(input logic [15:0] g);
        ok = 0; got = 0; lat = 0; wf = 0;
        guess_in = g;
        guess_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (guess_ready) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            guess_valid = 1'b0;
            return;
        end
        for (int k = 1; k < FT + 10; k++) begin
            @(negedge clk);
            if (k == 1) guess_valid = 1'b0;
            if (write_frame) wf++;
            if (result_valid) begin
                got = 1; lat = k;
                rb = result_bulls; rc = result_cows;
                rinv = result_invalid; rto = frame_timeout;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (secret_out !== 16'h8475) begin
            bad++; $display("FAIL reset_secret got=%h want=8475", secret_out);
        end
        total++;
        if ({guess_ready, write_frame, result_valid, done, win, frame_timeout,
             result_invalid, attempts, result_bulls, result_cows, score_guess} !== '0) begin
            bad++; $display("FAIL reset_outputs got nonzero want all zero");
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_win();
        reset_dut();
        start_game(0, '0);
        push(16'h8475, 0, 3);
        do_guess(16'h8475);
        total++;
        if (!got) begin
            bad++; $display("FAIL win_result got=none want=result_valid"); return;
        end
        e = q.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++; $display("FAIL win_latency got=%0d want=%0d", lat, e.lat);
        end
        total++;
        if ({rb, rc, rinv} !== {e.b, e.c, e.inv}) begin
            bad++; $display("FAIL win_score got=%0d/%0d/%0d want=%0d/%0d/%0d",
                            rb, rc, rinv, e.b, e.c, e.inv);
        end
        @(negedge clk);
        total++;
        if ({done, win, attempts} !== {1'b1, 1'b1, 4'd1}) begin
            bad++; $display("FAIL win_final got=%0d/%0d/%0d want=1/1/1", done, win, attempts);
        end
    endtask

    task automatic test_cows();
        reset_dut();
        start_game(0, '0);
        push(16'h5748, 0, 3);
        do_guess(16'h5748);
        total++;
        if (!got) begin
            bad++; $display("FAIL cows_result got=none want=result_valid"); return;
        end
        e = q.pop_front();
        total++;
        if ({rb, rc, rinv} !== {e.b, e.c, e.inv}) begin
            bad++; $display("FAIL cows_score got=%0d/%0d want=%0d/%0d", rb, rc, e.b, e.c);
        end
        @(negedge clk);
        total++;
        if ({guess_ready, done, attempts} !== {1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL cows_next got=%0d/%0d/%0d want=1/0/1",
                            guess_ready, done, attempts);
        end
    endtask

    task automatic test_invalid();
        logic [15:0] gs [2];
        gs[0] = 16'h3211;
        gs[1] = 16'h32A1;
        reset_dut();
        start_game(0, '0);
        for (int i = 0; i < 2; i++) begin
            push(gs[i], 1, 1);
            do_guess(gs[i]);
            total++;
            if (!got) begin
                bad++; $display("FAIL inv_result%0d got=none want=result_valid", i);
                continue;
            end
            e = q.pop_front();
            total++;
            if ({lat, rinv, wf} !== {e.lat, e.inv, 32'd0}) begin
                bad++; $display("FAIL inv_round%0d got=lat%0d/inv%0d/wf%0d want=lat%0d/inv1/wf0",
                                i, lat, rinv, wf, e.lat);
            end
            total++;
            if (attempts !== 4'd0) begin
                bad++; $display("FAIL inv_attempts%0d got=%0d want=0", i, attempts);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_lose();
        logic [15:0] gs [3];
        gs[0] = 16'h3210;
        gs[1] = 16'h9610;
        gs[2] = 16'h4785;
        reset_dut();
        start_game(0, '0);
        for (int i = 0; i < 3; i++) begin
            push(gs[i], 0, 3);
            do_guess(gs[i]);
            total++;
            if (!got) begin
                bad++; $display("FAIL lose_result%0d got=none want=result_valid", i);
                continue;
            end
            e = q.pop_front();
            total++;
            if ({rb, rc} !== {e.b, e.c}) begin
                bad++; $display("FAIL lose_score%0d got=%0d/%0d want=%0d/%0d",
                                i, rb, rc, e.b, e.c);
            end
            @(negedge clk);
        end
        total++;
        if ({done, win, attempts} !== {1'b1, 1'b0, 4'd3}) begin
            bad++; $display("FAIL lose_final got=%0d/%0d/%0d want=1/0/3", done, win, attempts);
        end
        do_guess(16'h3210);
        total++;
        if (ok || attempts !== 4'd3) begin
            bad++; $display("FAIL lose_extra got=acc%0d/att%0d want=acc0/att3", ok, attempts);
        end
    endtask

    task automatic test_timeout();
        reset_dut();
        start_game(0, '0);
        fw = 1'b0;
        do_guess(16'h3210);
        fw = 1'b1;
        total++;
        if (!got || wf !== FT || lat !== FT + 2 || rto !== 1'b1) begin
            bad++; $display("FAIL timeout_round got=wf%0d/lat%0d/to%0d want=wf%0d/lat%0d/to1",
                            wf, lat, rto, FT, FT + 2);
        end
        @(negedge clk);
        do_guess(16'h9610);
        @(negedge clk);
        do_guess(16'h6910);
        @(negedge clk);
        total++;
        if ({done, frame_timeout} !== 2'b11) begin
            bad++; $display("FAIL timeout_sticky got=%0d/%0d want=1/1", done, frame_timeout);
        end
        start_game(0, '0);
        total++;
        if ({frame_timeout, attempts, guess_ready} !== {1'b0, 4'd0, 1'b1}) begin
            bad++; $display("FAIL timeout_clear got=%0d/%0d/%0d want=0/0/1",
                            frame_timeout, attempts, guess_ready);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        start_game(1, 16'h4321);
        total++;
        if (secret_out !== 16'h4321) begin
            bad++; $display("FAIL mid_load got=%h want=4321", secret_out);
        end
        fw = 1'b0;
        guess_in = 16'h3210;
        guess_valid = 1'b1;
        for (int i = 0; i < 10 && !write_frame; i++) begin
            @(negedge clk);
            guess_valid = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({write_frame, result_valid, secret_out} !== {2'b00, 16'h8475}) begin
            bad++; $display("FAIL mid_reset got=wf%0d/rv%0d/%h want=wf0/rv0/8475",
                            write_frame, result_valid, secret_out);
        end
        @(negedge clk);
        rst = 1'b1;
        fw = 1'b1;
        @(negedge clk);
        start_game(0, '0);
        do_guess(16'h8475);
        @(negedge clk);
        secret_we = 1'b1;
        secret_in = 16'h3211;
        @(negedge clk);
        secret_we = 1'b0;
        total++;
        if ({done, secret_out} !== {1'b1, 16'h8475}) begin
            bad++; $display("FAIL mid_badsecret got=%0d/%h want=1/8475", done, secret_out);
        end
        start_game(1, 16'h4321);
        exp_secret = 16'h4321;
        push(16'h4321, 0, 3);
        do_guess(16'h4321);
        total++;
        if (!got) begin
            bad++; $display("FAIL mid_result got=none want=result_valid"); return;
        end
        e = q.pop_front();
        total++;
        if ({rb, rc, lat} !== {e.b, e.c, e.lat}) begin
            bad++; $display("FAIL mid_score got=%0d/%0d/lat%0d want=%0d/%0d/lat%0d",
                            rb, rc, lat, e.b, e.c, e.lat);
        end
        @(negedge clk);
        total++;
        if ({done, win} !== 2'b11) begin
            bad++; $display("FAIL mid_win got=%0d/%0d want=1/1", done, win);
        end
    endtask

    initial begin
        test_reset();
        test_win();
        test_cows();
        test_invalid();
        test_lose();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
